// File: rtl/paint_fb_writer.sv
// Paint-command consumer: decodes packed paint words, buffers them in a FIFO and
// drives the frame-buffer write port; also sweeps the whole buffer with a fill colour.
module paint_fb_writer #(
    parameter int FB_DEPTH   = 65536,
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [31:0]      cmd_data,
    output logic             cmd_ready,
    input  logic             fill_req,
    input  logic [11:0]      fill_color,
    output logic             fb_we,
    output logic [15:0]      fb_addr,
    output logic [11:0]      fb_din,
    output logic             busy,
    output logic [LVL_W-1:0] fifo_level,
    output logic [7:0]       err_cnt
);

    localparam int               PTR_W      = LVL_W - 1;
    localparam logic [31:0]      FB_DEPTH_U = FB_DEPTH;
    localparam logic [15:0]      LAST_ADDR  = 16'(FB_DEPTH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL   = LVL_W'(FIFO_DEPTH);

    typedef enum logic {IDLE, FILL} state_t;

    state_t             state_q, state_d;
    logic [27:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   count_q, count_d;
    logic               fill_pend_q, fill_pend_d;
    logic [11:0]        fill_col_q, fill_col_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [15:0]        addr_q, addr_d;
    logic [11:0]        din_q, din_d;
    logic [7:0]         err_q, err_d;

    logic [3:0]         en;
    logic               addr_ok, accept, push, bad, pop;
    logic [27:0]        head;

    assign en        = cmd_data[31:28];
    assign addr_ok   = {16'h0, cmd_data[15:0]} < FB_DEPTH_U;
    assign cmd_ready = ~rst & (count_q != FULL_LVL);
    assign accept    = cmd_valid & cmd_ready;
    assign push      = accept & (en == 4'hF) & addr_ok;
    // en==0 is an idle painter: consumed without counting as an error
    assign bad       = accept & (en != 4'h0) & ~((en == 4'hF) & addr_ok);
    assign head      = mem[rd_ptr];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        din_d       = din_q;
        pop         = 1'b0;
        fill_pend_d = fill_pend_q;
        fill_col_d  = fill_col_q;
        case (state_q)
            IDLE: begin
                if (fill_pend_q) begin
                    // the write of address 0 is issued on the transition edge itself
                    fill_pend_d = 1'b0;
                    we_d        = 1'b1;
                    addr_d      = '0;
                    din_d       = fill_col_q;
                    if (LAST_ADDR != 16'h0) begin
                        state_d = FILL;
                        cnt_d   = 16'd1;
                    end
                end else begin
                    if (count_q != '0) begin
                        pop    = 1'b1;
                        we_d   = 1'b1;
                        addr_d = head[15:0];
                        din_d  = head[27:16];
                    end
                    if (fill_req) begin
                        fill_pend_d = 1'b1;
                        fill_col_d  = fill_color;
                    end
                end
            end
            FILL: begin
                we_d   = 1'b1;
                addr_d = cnt_q;
                din_d  = fill_col_q;
                cnt_d  = cnt_q + 16'd1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        err_d = err_q;
        if (bad && err_q != 8'hFF)
            err_d = err_q + 8'd1;

        count_d = count_q;
        if (push && !pop)
            count_d = count_q + LVL_W'(1);
        else if (!push && pop)
            count_d = count_q - LVL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            fill_pend_q <= 1'b0;
            fill_col_q  <= '0;
            err_q       <= '0;
            count_q     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            fill_pend_q <= fill_pend_d;
            fill_col_q  <= fill_col_d;
            err_q       <= err_d;
            count_q     <= count_d;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {cmd_data[27:16], cmd_data[15:0]};
    end

    assign fb_we      = we_q;
    assign fb_addr    = addr_q;
    assign fb_din     = din_q;
    assign err_cnt    = err_q;
    assign fifo_level = count_q;
    assign busy       = fill_pend_q | (state_q == FILL) | (count_q != '0);

endmodule

// File: tb/tb_paint_fb_writer.sv
// Directed bench for paint_fb_writer with a 16-pixel frame buffer.
module tb_paint_fb_writer;

    logic        clk = 1'b0;
    logic        rst, cmd_valid, cmd_ready, fill_req, fb_we, busy;
    logic [31:0] cmd_data;
    logic [11:0] fill_color, fb_din;
    logic [15:0] fb_addr;
    logic [3:0]  fifo_level;
    logic [7:0]  err_cnt;

    int npass = 0;
    int ntotal = 0;
    int cyc = 0;
    logic [15:0] log_addr[$];
    logic [11:0] log_din[$];
    int          log_cyc[$];

    paint_fb_writer #(.FB_DEPTH(16), .FIFO_DEPTH(8), .LVL_W(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .fill_req(fill_req), .fill_color(fill_color),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_din(fb_din), .busy(busy),
        .fifo_level(fifo_level), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (fb_we) begin
            log_addr.push_back(fb_addr);
            log_din.push_back(fb_din);
            log_cyc.push_back(cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, required finish before 100000");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_din.delete();
        log_cyc.delete();
    endtask

    initial begin
        int budget;
        rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; fill_req = 1'b0; fill_color = '0;
        tick(); tick();
        chk("rst_we", 32'(fb_we), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_err", 32'(err_cnt), 0);
        chk("rst_ready", 32'(cmd_ready), 0);
        rst = 1'b0; #1;
        chk("ready_after_rst", 32'(cmd_ready), 1);

        // single pixel
        cmd_valid = 1'b1; cmd_data = 32'hF0A5_000B;
        tick();
        cmd_valid = 1'b0;
        chk("px_we_early", 32'(fb_we), 0);
        chk("px_level", 32'(fifo_level), 1);
        chk("px_busy", 32'(busy), 1);
        tick();
        chk("px_we", 32'(fb_we), 1);
        chk("px_addr", 32'(fb_addr), 32'h000B);
        chk("px_din", 32'(fb_din), 32'h0A5);
        tick();
        chk("px_we_off", 32'(fb_we), 0);
        chk("px_addr_hold", 32'(fb_addr), 32'h000B);
        chk("px_busy_off", 32'(busy), 0);
        chk("px_err", 32'(err_cnt), 0);

        // drops and errors
        cmd_valid = 1'b1; cmd_data = 32'h0123_0004;
        tick();
        cmd_valid = 1'b0;
        chk("idle_level", 32'(fifo_level), 0);
        chk("idle_err", 32'(err_cnt), 0);
        tick();
        chk("idle_we", 32'(fb_we), 0);
        cmd_valid = 1'b1; cmd_data = 32'h3FFF_0002;
        tick();
        cmd_valid = 1'b0;
        chk("en3_err", 32'(err_cnt), 1);
        chk("en3_level", 32'(fifo_level), 0);
        tick();
        chk("en3_we", 32'(fb_we), 0);
        cmd_valid = 1'b1; cmd_data = 32'hF123_0010;
        tick();
        cmd_data = 32'hF0A5_0123;
        tick();
        cmd_valid = 1'b0;
        chk("range_err", 32'(err_cnt), 3);
        chk("range_level", 32'(fifo_level), 0);
        cmd_valid = 1'b1; cmd_data = 32'h5ABC_0001;
        for (int i = 0; i < 300; i++) tick();
        cmd_valid = 1'b0;
        chk("err_sat", 32'(err_cnt), 255);
        tick();
        chk("err_sat_we", 32'(fb_we), 0);

        // fill with backpressure
        clear_log();
        fill_req = 1'b1; fill_color = 12'hFFF;
        tick();
        fill_req = 1'b0;
        chk("fill_pend_busy", 32'(busy), 1);
        chk("fill_pend_we", 32'(fb_we), 0);
        tick();
        chk("fill_first_we", 32'(fb_we), 1);
        chk("fill_first_addr", 32'(fb_addr), 0);
        chk("fill_first_din", 32'(fb_din), 32'hFFF);
        for (int i = 0; i < 9; i++) begin
            cmd_valid = 1'b1;
            cmd_data = {4'hF, 12'(12'h100 + i), 16'(i)};
            chk($sformatf("bp_ready_%0d", i), 32'(cmd_ready), (i < 8) ? 1 : 0);
            if (i < 8) tick();
        end
        chk("bp_level_full", 32'(fifo_level), 8);
        budget = 0;
        while (!cmd_ready && budget < 50) begin
            tick();
            budget++;
        end
        chk("bp_ready_wait", 32'(budget < 50), 1);
        tick();
        cmd_valid = 1'b0;
        repeat (12) tick();
        chk("bp_log_size", 32'(log_addr.size()), 25);
        for (int i = 0; i < 25; i++) begin
            if (i < log_addr.size()) begin
                if (i < 16) begin
                    chk($sformatf("fill_addr_%0d", i), 32'(log_addr[i]), i);
                    chk($sformatf("fill_din_%0d", i), 32'(log_din[i]), 32'hFFF);
                end else begin
                    chk($sformatf("bp_addr_%0d", i - 16), 32'(log_addr[i]), i - 16);
                    chk($sformatf("bp_din_%0d", i - 16), 32'(log_din[i]), 32'h100 + i - 16);
                end
                if (i > 0 && i < 17)
                    chk($sformatf("back2back_%0d", i), 32'(log_cyc[i] - log_cyc[i-1]), 1);
            end
        end
        chk("bp_busy_end", 32'(busy), 0);
        chk("bp_level_end", 32'(fifo_level), 0);

        // fill beats a command accepted on the same edge
        clear_log();
        fill_req = 1'b1; fill_color = 12'h3C0;
        cmd_valid = 1'b1; cmd_data = 32'hF7E1_0005;
        tick();
        fill_req = 1'b0; cmd_valid = 1'b0;
        chk("prio_level", 32'(fifo_level), 1);
        chk("prio_we_early", 32'(fb_we), 0);
        tick();
        chk("prio_first_addr", 32'(fb_addr), 0);
        chk("prio_first_din", 32'(fb_din), 32'h3C0);
        repeat (18) tick();
        chk("prio_log_size", 32'(log_addr.size()), 17);
        if (log_addr.size() >= 17) begin
            chk("prio_fill_last", 32'(log_addr[15]), 15);
            chk("prio_px_addr", 32'(log_addr[16]), 5);
            chk("prio_px_din", 32'(log_din[16]), 32'h7E1);
        end
        chk("prio_err_kept", 32'(err_cnt), 255);

        // reset in the middle of a fill
        fill_req = 1'b1; fill_color = 12'h0AA;
        cmd_valid = 1'b1; cmd_data = 32'hF111_0003;
        tick();
        fill_req = 1'b0; cmd_valid = 1'b0;
        repeat (6) tick();
        chk("mid_we", 32'(fb_we), 1);
        chk("mid_addr", 32'(fb_addr), 5);
        rst = 1'b1;
        tick();
        chk("mrst_we", 32'(fb_we), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_level", 32'(fifo_level), 0);
        chk("mrst_err", 32'(err_cnt), 0);
        chk("mrst_addr", 32'(fb_addr), 0);
        chk("mrst_ready", 32'(cmd_ready), 0);
        rst = 1'b0;
        clear_log();
        repeat (20) tick();
        chk("mrst_no_writes", 32'(log_addr.size()), 0);
        chk("mrst_busy_after", 32'(busy), 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
